// File: rtl/seq_shift_rotate.sv
// Multi-cycle shift/rotate unit: applies one single-bit shift or rotate per
// clock until the requested amount is exhausted, then pulses done with the
// result and carry/zero/overflow/error flags.
module seq_shift_rotate #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam logic [2:0] OP_SRA = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SLA = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             illegal_op;
  logic             step_hit;
  logic             step_carry;
  logic [WIDTH-1:0] step_r;

  // One single-bit step: returns {sign-change hit (sla only), bit out, new r}.
  function automatic logic [WIDTH+1:0] step_fn(input logic [2:0] op,
                                               input logic [WIDTH-1:0] r);
    logic signed [WIDTH-1:0] r_s;
    logic [WIDTH-1:0]        r_n;
    logic                    c;
    logic                    hit;
    r_s = r;
    r_n = r;
    c   = 1'b0;
    hit = 1'b0;
    case (op)
      OP_SRA: begin r_n = $unsigned(r_s >>> 1); c = r[0]; end
      OP_SRL: begin r_n = r >> 1; c = r[0]; end
      OP_SLA: begin
        r_n = r << 1;
        c   = r[WIDTH-1];
        hit = r[WIDTH-1] ^ r[WIDTH-2];
      end
      OP_SLL: begin r_n = r << 1; c = r[WIDTH-1]; end
      OP_ROR: begin r_n = {r[0], r[WIDTH-1:1]}; c = r[0]; end
      OP_ROL: begin r_n = {r[WIDTH-2:0], r[WIDTH-1]}; c = r[WIDTH-1]; end
      default: ;
    endcase
    return {hit, c, r_n};
  endfunction

  assign illegal_op = opcode[2] & opcode[1];

  // Next-state logic: acceptance in IDLE/DONE, one step per cycle in SHIFT.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    op_d    = op_q;
    count_d = count_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    {step_hit, step_carry, step_r} = step_fn(op_q, r_q);
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_d    = opcode;
          count_d = amt;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          err_d   = illegal_op;
          // An illegal opcode reports a cleared result rather than the operand.
          r_d     = illegal_op ? '0 : a;
          state_d = (illegal_op || amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        r_d     = step_r;
        carry_d = step_carry;
        ovf_d   = ovf_q | step_hit;
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and working registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      op_q    <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      op_q    <= op_d;
      count_q <= count_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = r_q;
  assign zero   = ~|r_q;
  assign carry  = carry_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_seq_shift_rotate.sv
// Scoreboard bench for seq_shift_rotate: an 8-bit instance (4-bit amount so
// amounts beyond the width are reachable) and a 16-bit instance.
`timescale 1ns/1ps
module tb_seq_shift_rotate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        s8, busy8, done8, carry8, zero8, ovf8, err8;
  logic [2:0]  op8;
  logic [7:0]  a8, res8;
  logic [3:0]  amt8;

  logic        s16, busy16, done16, carry16, zero16, ovf16, err16;
  logic [2:0]  op16;
  logic [15:0] a16, res16;
  logic [3:0]  amt16;

  seq_shift_rotate #(.WIDTH(8), .AMT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .opcode(op8), .a(a8), .amt(amt8),
    .busy(busy8), .done(done8), .result(res8), .carry(carry8), .zero(zero8),
    .ovf(ovf8), .err(err8));

  seq_shift_rotate #(.WIDTH(16), .AMT_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .opcode(op16), .a(a16), .amt(amt16),
    .busy(busy16), .done(done16), .result(res16), .carry(carry16), .zero(zero16),
    .ovf(ovf16), .err(err16));

  typedef struct {
    logic [31:0] res;
    logic        carry;
    logic        zero;
    logic        ovf;
    logic        err;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mode[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic gb(input logic [31:0] v, input int idx);
    return (idx < 0) ? 1'b0 : v[idx];
  endfunction

  // Reference: closed-form result of k single-bit operations on a w-bit value.
  function automatic exp_t model(input int w, input logic [2:0] op,
                                 input logic [31:0] av, input int k);
    exp_t e;
    logic [31:0] mask, a, r;
    logic signed [31:0] sa;
    int s;
    mask = (32'h1 << w) - 32'h1;
    a = av & mask;
    r = '0;
    e.carry = 1'b0; e.ovf = 1'b0; e.err = 1'b0;
    case (op)
      3'd0: begin
        sa = $signed(a << (32 - w)) >>> (32 - w);
        r = $unsigned(sa >>> ((k > 31) ? 31 : k)) & mask;
        if (k > 0) e.carry = sa[(k - 1 > 31) ? 31 : k - 1];
      end
      3'd1: begin
        r = (k >= w) ? 32'h0 : (a >> k);
        if (k > 0 && k <= w) e.carry = a[k-1];
      end
      3'd2, 3'd3: begin
        r = (k >= w) ? 32'h0 : ((a << k) & mask);
        if (k > 0 && k <= w) e.carry = a[w-k];
        if (op == 3'd2)
          for (int i = 0; i < k && i < w; i++)
            if (gb(a, w - 1 - i) != gb(a, w - 2 - i)) e.ovf = 1'b1;
      end
      3'd4: begin
        s = k % w;
        r = ((a >> s) | (a << (w - s))) & mask;
        if (k > 0) e.carry = r[w-1];
      end
      3'd5: begin
        s = k % w;
        r = ((a << s) | (a >> (w - s))) & mask;
        if (k > 0) e.carry = r[0];
      end
      default: e.err = 1'b1;
    endcase
    e.res  = r;
    e.zero = (r == 32'h0);
    e.lat  = (e.err || k == 0) ? 0 : k;
    e.cyc  = 0;
    return e;
  endfunction

  function automatic logic busy_of(input int d); return d == 0 ? busy8 : busy16; endfunction
  function automatic logic done_of(input int d); return d == 0 ? done8 : done16; endfunction
  function automatic logic [31:0] res_of(input int d);
    return d == 0 ? {24'h0, res8} : {16'h0, res16};
  endfunction
  function automatic logic [3:0] flags_of(input int d);
    return d == 0 ? {carry8, zero8, ovf8, err8} : {carry16, zero16, ovf16, err16};
  endfunction
  function automatic int qsize(input int d); return d == 0 ? q8.size() : q16.size(); endfunction
  function automatic void qpush(input int d, input exp_t e);
    if (d == 0) q8.push_back(e); else q16.push_back(e);
  endfunction
  function automatic exp_t qpop(input int d);
    return d == 0 ? q8.pop_front() : q16.pop_front();
  endfunction
  function automatic void qclear(input int d);
    if (d == 0) q8.delete(); else q16.delete();
  endfunction

  task automatic set_in(input int d, input logic s, input logic [2:0] op,
                        input logic [15:0] a, input logic [3:0] amt);
    if (d == 0) begin s8 = s; op8 = op; a8 = a[7:0]; amt8 = amt; end
    else begin s16 = s; op16 = op; a16 = a; amt16 = amt; end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) s8 = v; else s16 = v;
  endtask

  // Advance to a cycle where a request would be accepted; inject noise meanwhile.
  task automatic wait_free(input int d);
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy_of(d)) break;
      n++;
      if (mode[d] == 2) set_in(d, 1'($urandom), 3'($urandom), 16'($urandom), 4'($urandom));
      if (n > 100) begin
        total++; bad++;
        $display("FAIL dut%0d busy timeout", d);
        break;
      end
    end
  endtask

  // md: 0 drop start after acceptance, 1 hold start high, 2 random start pulses while busy.
  task automatic issue(input int d, input logic [2:0] op, input logic [15:0] a,
                       input logic [3:0] amt, input int md);
    exp_t e;
    wait_free(d);
    set_in(d, 1'b1, op, a, amt);
    e = model(d == 0 ? 8 : 16, op, {16'h0, a}, int'(amt));
    e.cyc = cyc + 1 + e.lat;
    qpush(d, e);
    mode[d] = md;
    @(posedge clk);
    #1;
    if (md != 1) set_start(d, 1'b0);
  endtask

  task automatic idle(input int d);
    int n = 0;
    wait_free(d);
    set_start(d, 1'b0);
    mode[d] = 0;
    while (qsize(d) != 0 && n < 20) begin @(negedge clk); n++; end
    check($sformatf("dut%0d drain pending", d), qsize(d), 0);
  endtask

  task automatic chk_reset(input int d);
    check($sformatf("dut%0d reset result", d), res_of(d), 32'h0);
    check($sformatf("dut%0d reset busy", d), busy_of(d), 1'b0);
    check($sformatf("dut%0d reset done", d), done_of(d), 1'b0);
    check($sformatf("dut%0d reset {carry,zero,ovf,err}", d), flags_of(d), 4'b0100);
  endtask

  task automatic mon(input int d);
    exp_t e;
    int bc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bc = 0;
        qclear(d);
      end else begin
        if (busy_of(d)) bc++;
        if (done_of(d)) begin
          if (qsize(d) == 0) begin
            total++; bad++;
            $display("FAIL dut%0d unexpected done result=%0h", d, res_of(d));
          end else begin
            e = qpop(d);
            check($sformatf("dut%0d result", d), res_of(d), e.res);
            check($sformatf("dut%0d carry", d), flags_of(d)[3], e.carry);
            check($sformatf("dut%0d zero", d), flags_of(d)[2], e.zero);
            check($sformatf("dut%0d ovf", d), flags_of(d)[1], e.ovf);
            check($sformatf("dut%0d err", d), flags_of(d)[0], e.err);
            check($sformatf("dut%0d busy cycles", d), bc, e.lat);
            check($sformatf("dut%0d done cycle", d), cyc, e.cyc);
            check($sformatf("dut%0d busy during done", d), busy_of(d), 1'b0);
          end
          bc = 0;
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    mode[0] = 0; mode[1] = 0;
    set_in(0, 1'b0, 3'd0, 16'h0, 4'd0);
    set_in(1, 1'b0, 3'd0, 16'h0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk); #2 rst_n = 1'b1;

    // Reset in the middle of a shift, then normal operation resumes.
    issue(0, 3'b011, 16'h00F0, 4'd5, 0);
    @(posedge clk); @(posedge clk);
    #1 check("dut0 mid-shift result", res_of(0), 32'hC0);
    check("dut0 mid-shift busy", busy_of(0), 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_reset(0);
    @(negedge clk); #2 rst_n = 1'b1;

    issue(0, 3'b000, 16'h0081, 4'd3, 0);
    issue(0, 3'b100, 16'h0096, 4'd11, 0);
    issue(0, 3'b010, 16'h0040, 4'd1, 0);
    issue(0, 3'b001, 16'h0001, 4'd1, 0);
    issue(0, 3'b101, 16'h005A, 4'd0, 0);
    issue(0, 3'b111, 16'h00FF, 4'd4, 0);
    issue(0, 3'b110, 16'h0033, 4'd0, 0);
    issue(0, 3'b000, 16'h0080, 4'd12, 0);
    issue(0, 3'b010, 16'h0001, 4'd9, 0);
    // start held high across back-to-back operations
    issue(0, 3'b001, 16'h00C3, 4'd2, 1);
    issue(0, 3'b101, 16'h00C3, 4'd1, 1);
    // random start pulses while shifting must be ignored
    issue(0, 3'b011, 16'h00A5, 4'd6, 2);
    issue(0, 3'b100, 16'h0017, 4'd5, 2);
    for (int i = 0; i < 40; i++)
      issue(0, 3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom), $urandom_range(0, 2));
    idle(0);

    issue(1, 3'b101, 16'h8001, 4'd15, 2);
    issue(1, 3'b001, 16'hFFFF, 4'd2, 1);
    issue(1, 3'b101, 16'h1234, 4'd1, 1);
    for (int i = 0; i < 25; i++)
      issue(1, 3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom), $urandom_range(0, 2));
    idle(1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_shift_rotate.md
# seq_shift_rotate

Multi-cycle, parametrised shift/rotate unit. It accepts an operand, an opcode and a shift amount, then applies one single-bit shift or rotate per clock until the amount is exhausted. It reports the result with carry, zero and overflow flags behind a start/busy/done handshake. It sits beside the combinational single-bit shifter in the datapath and is used for variable-distance shifts on operands of any width.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- AMT_W, 3, width of shift-amount port; covers at least WIDTH-1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- opcode  input  3  000 sra, 001 srl, 010 sla, 011 sll, 100 ror, 101 rol; 110/111 illegal
- a  input  WIDTH  operand, latched on acceptance
- amt  input  AMT_W  number of single-bit steps, latched on acceptance
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result/flags valid
- result  output  WIDTH  operand after amt steps; held until next acceptance
- carry  output  1  last bit shifted or rotated out; 0 when amt=0
- zero  output  1  result == 0
- ovf  output  1  sla only: sign bit changed on any step
- err  output  1  illegal opcode on last accepted request

## Operation
- States: IDLE, SHIFT, DONE.
- Acceptance: start=1 in IDLE or DONE at a rising edge. On that edge, latch a into the working register, latch opcode and amt, clear carry/ovf/err, load count = amt.
  - Legal opcode, amt≠0: go to SHIFT.
  - amt=0 or illegal opcode: go directly to DONE.
- SHIFT: each edge applies one step, decrements count, and goes to DONE on the edge where count reaches 0.
- Step definitions (r = working register, N = WIDTH-1):
  - sra: r = {r[N], r[N:1]}, carry = r[0]
  - srl: r = {0, r[N:1]}, carry = r[0]
  - sla: r = {r[N-1:0], 0}, carry = r[N]; ovf sets sticky if r[N] ≠ r[N-1]
  - sll: r = {r[N-1:0], 0}, carry = r[N]
  - ror: r = {r[0], r[N:1]}, carry = r[0]
  - rol: r = {r[N-1:0], r[N]}, carry = r[N]
- amt ≥ WIDTH is legal and steps amt times. Logical shifts reach 0; sra saturates at all-sign; rotates wrap modulo WIDTH.
- Illegal opcode: result = 0, err = 1, carry = ovf = 0.
- zero is combinational on result and is valid whenever done=1.
- DONE: done=1 and busy=0 for exactly one cycle.
  - Next state is IDLE, or acceptance of a new request if start=1.
- start while in SHIFT is ignored; no queueing.
- result is the working register and is updated only on steps and acceptance. The value is stable from done until the next acceptance.

## Timing
- Reset (asynchronous, any state, including mid-SHIFT): state IDLE; result 0; carry, ovf, err, busy, done all 0; zero 1 (result=0); count 0.
- Deassertion of rst_n takes effect at the next clock edge. No request is accepted on the edge coincident with deassertion.
- Acceptance edge is E0.
- busy is high in the cycles after E0 while state = SHIFT (amt cycles, 0 when amt=0).
- done is high in the cycle after edge E0+amt: amt=0 → cycle after E0; amt=k → cycle after E0+k.
- Illegal opcode gives done in the cycle after E0.
- Back-to-back: start=1 during the done cycle is accepted on that edge. Zero idle cycles between operations.
- Throughput: one operation per amt+1 cycles (min 1).

## Test plan
- Reset mid-SHIFT (WIDTH=8, a=8'hF0, sll, amt=5, rst_n low after 2 steps) -> all outputs 0 immediately except zero=1; next op runs normally.
- WIDTH=8, a=8'h81, sra, amt=3 -> done 3 cycles after E0; result=8'hF0; carry=0; busy high exactly 3 cycles.
- WIDTH=8, a=8'h96, ror, amt=11 -> result=8'hD2 (rotate by 3); carry=1.
- WIDTH=8, a=8'h40, sla, amt=1 -> result=8'h80, ovf=1, carry=0; then srl a=8'h01 amt=1 -> result=0, zero=1, carry=1, ovf=0.
- amt=0 with a=8'h5A, rol -> done cycle after E0, result=8'h5A, carry=0. Opcode 3'b111 -> result=0, err=1, zero=1.
- Back-to-back and ignored start: start held high continuously (srl amt=2, then rol amt=1) -> second op accepted on first done edge. start pulses during SHIFT are ignored. Repeat with WIDTH=16, AMT_W=4, a=16'h8001, rol amt=15 -> result=16'hC000.
